ex_muldiv_stage: RTL and testbench
==================================

EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-003 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have i_id_ex_data_1  input  DATA_WIDTH  rs register value.
REQ-006 SHALL have i_id_ex_data_2  input  DATA_WIDTH  rt register value.
REQ-007 SHALL have i_id_ex_rs / i_id_ex_rt / i_id_ex_rd  input  REG_ADDR_W each  source/destination indices.
REQ-008 SHALL have i_id_ex_extended_beq_offset  input  DATA_WIDTH  sign-extended immediate.
REQ-009 SHALL have i_id_ex_reg_dst  input  1  1 = rd is destination, 0 = rt.
REQ-010 SHALL have i_id_ex_alu_src  input  1  1 = operand B is immediate.
REQ-011 SHALL have i_id_ex_alu_op  input  4  operation select (REQ-027).
REQ-012 SHALL have i_id_ex_ctrl  input  4  {mem_read, mem_write, mem_to_reg, reg_write}.
REQ-013 SHALL have i_ex_m_alu_result / i_ex_m_reg_write / i_ex_m_rd  input  DATA_WIDTH/1/REG_ADDR_W  EX/M forwarding source.
REQ-014 SHALL have i_m_wb_data_write / i_m_wb_reg_write / i_m_wb_rd  input  DATA_WIDTH/1/REG_ADDR_W  M/WB forwarding source.
REQ-015 SHALL have o_ex_m_alu_result  output  DATA_WIDTH  registered result.
REQ-016 SHALL have o_ex_m_write_data  output  DATA_WIDTH  registered forwarded operand B (pre-immediate mux).
REQ-017 SHALL have o_ex_m_rd  output  REG_ADDR_W  registered destination index.
REQ-018 SHALL have o_ex_m_ctrl  output  4  registered control bits.
REQ-019 SHALL have o_ex_stall  output  1  combinational; 1 = upstream must hold ID/EX inputs.
REQ-020 SHALL have o_muldiv_busy  output  1  registered; 1 = iterative unit in BUSY.

Function
REQ-021 Forwarding A SHALL select i_ex_m_alu_result if i_ex_m_reg_write, i_ex_m_rd!=0, i_ex_m_rd==rs; else i_m_wb_data_write under same test on M/WB; else data_1 (EX/M wins ties).
REQ-022 Forwarding B SHALL apply REQ-021 rules with rt and data_2; operand B = immediate when alu_src=1.
REQ-023 Destination SHALL be rd when reg_dst=1, else rt.
REQ-024 Non-stalled cycle: EX/M registers SHALL load result, forwarded B, destination, ctrl on next edge (latency 1).
REQ-025 Stalled cycle: EX/M registers SHALL load a bubble (result 0, write data 0, rd 0, ctrl 0).
REQ-026 All arithmetic SHALL wrap modulo 2^DATA_WIDTH; no overflow trap.
REQ-027 alu_op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT (signed, result 0/1), 0111 SLTU, 1000 SLLV, 1001 SRLV, 1010 SRAV (B shifted by A[log2(DATA_WIDTH)-1:0]), 1011 MULTU, 1100 DIVU, 1101 MFHI, 1110 MFLO, 1111 LUI (B << DATA_WIDTH/2).
REQ-028 Muldiv FSM SHALL have states IDLE, BUSY; IDLE + non-stalled MULTU/DIVU -> latch operands, counter=DATA_WIDTH, BUSY; that instruction passes to EX/M with ctrl forced 0.
REQ-029 BUSY SHALL perform one shift-add (MULTU) or restoring-subtract (DIVU) iteration per cycle, decrement counter, write HI/LO and return to IDLE on the edge where counter reaches 0.
REQ-030 MULTU SHALL give {HI,LO} = 2*DATA_WIDTH-bit unsigned product; DIVU SHALL give LO = quotient, HI = remainder.
REQ-031 DIVU by zero SHALL complete in normal latency with LO = all ones, HI = dividend.
REQ-032 o_ex_stall SHALL be 1 iff FSM is BUSY and alu_op is MULTU, DIVU, MFHI or MFLO; other ops proceed concurrently.
REQ-033 MFHI/MFLO non-stalled SHALL return current HI/LO.

Reset
REQ-034 i_reset=0 SHALL immediately clear all EX/M outputs, HI, LO, counter, o_muldiv_busy to 0 and FSM to IDLE, including mid-BUSY; o_ex_stall=0 during reset.
REQ-035 First edge after i_reset returns to 1 SHALL perform normal operation.

Verification
REQ-036 ADD data_1=0, imm=5, alu_src=1, reg_dst=0, rt=9, ctrl=0001 -> after one edge result=5, rd=9, ctrl=0001.
REQ-037 rs=8, EX/M rd=8 value 100, M/WB rd=8 value 200, both reg_write -> operand A=100; repeat with index 0 -> data_1 used.
REQ-038 MULTU 0xFFFFFFFF*2, then MFLO next cycle -> o_ex_stall=1 for 32 cycles with bubbles, MFLO result 0xFFFFFFFE, MFHI gives 1.
REQ-039 DIVU 100/7 -> LO=14, HI=2; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7; ADD issued during BUSY not stalled.
REQ-040 SLT -1 vs 1 -> 1; SLTU same operands -> 0; SRAV 0x80000000 by 4 -> 0xF8000000.
REQ-041 i_reset=0 at BUSY cycle 10 -> outputs, HI/LO, o_muldiv_busy, o_ex_stall all 0 without clock edge.

Source files
------------

// File: rtl/ex_muldiv_stage.sv
// Execute stage: forwarding, single-cycle ALU and an iterative multiply/divide unit
// with HI/LO registers, feeding the EX/M pipeline register.
module ex_muldiv_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_id_ex_data_1,
  input  logic [DATA_WIDTH-1:0] i_id_ex_data_2,
  input  logic [REG_ADDR_W-1:0] i_id_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_id_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_ex_rd,
  input  logic [DATA_WIDTH-1:0] i_id_ex_extended_beq_offset,
  input  logic                  i_id_ex_reg_dst,
  input  logic                  i_id_ex_alu_src,
  input  logic [3:0]            i_id_ex_alu_op,
  input  logic [3:0]            i_id_ex_ctrl,
  input  logic [DATA_WIDTH-1:0] i_ex_m_alu_result,
  input  logic                  i_ex_m_reg_write,
  input  logic [REG_ADDR_W-1:0] i_ex_m_rd,
  input  logic [DATA_WIDTH-1:0] i_m_wb_data_write,
  input  logic                  i_m_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_m_wb_rd,
  output logic [DATA_WIDTH-1:0] o_ex_m_alu_result,
  output logic [DATA_WIDTH-1:0] o_ex_m_write_data,
  output logic [REG_ADDR_W-1:0] o_ex_m_rd,
  output logic [3:0]            o_ex_m_ctrl,
  output logic                  o_ex_stall,
  output logic                  o_muldiv_busy
);

  localparam int unsigned ShW  = $clog2(DATA_WIDTH);
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpNor   = 4'b0101;
  localparam logic [3:0] OpSlt   = 4'b0110;
  localparam logic [3:0] OpSltu  = 4'b0111;
  localparam logic [3:0] OpSllv  = 4'b1000;
  localparam logic [3:0] OpSrlv  = 4'b1001;
  localparam logic [3:0] OpSrav  = 4'b1010;
  localparam logic [3:0] OpMultu = 4'b1011;
  localparam logic [3:0] OpDivu  = 4'b1100;
  localparam logic [3:0] OpMfhi  = 4'b1101;
  localparam logic [3:0] OpMflo  = 4'b1110;
  localparam logic [3:0] OpLui   = 4'b1111;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [DATA_WIDTH-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic [REG_ADDR_W-1:0] dest;
  logic [ShW-1:0]        shamt;
  logic                  md_start, md_use, stall;

  logic [0:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  div_q, div_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, wrk_q, wrk_d, opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_WIDTH-1:0] acc_nxt, wrk_nxt, div_diff;
  logic [DATA_WIDTH:0]   mul_sum, div_shift;
  logic                  div_ge;

  // EX/M is the newer producer, so it wins when both stages target the same register.
  always_comb begin
    if (i_ex_m_reg_write && (i_ex_m_rd != '0) && (i_ex_m_rd == i_id_ex_rs)) begin
      fwd_a = i_ex_m_alu_result;
    end else if (i_m_wb_reg_write && (i_m_wb_rd != '0) && (i_m_wb_rd == i_id_ex_rs)) begin
      fwd_a = i_m_wb_data_write;
    end else begin
      fwd_a = i_id_ex_data_1;
    end
    if (i_ex_m_reg_write && (i_ex_m_rd != '0) && (i_ex_m_rd == i_id_ex_rt)) begin
      fwd_b = i_ex_m_alu_result;
    end else if (i_m_wb_reg_write && (i_m_wb_rd != '0) && (i_m_wb_rd == i_id_ex_rt)) begin
      fwd_b = i_m_wb_data_write;
    end else begin
      fwd_b = i_id_ex_data_2;
    end
  end

  assign op_a  = fwd_a;
  assign op_b  = i_id_ex_alu_src ? i_id_ex_extended_beq_offset : fwd_b;
  assign dest  = i_id_ex_reg_dst ? i_id_ex_rd : i_id_ex_rt;
  assign shamt = op_a[ShW-1:0];

  assign md_start = (i_id_ex_alu_op == OpMultu) || (i_id_ex_alu_op == OpDivu);
  assign md_use   = md_start || (i_id_ex_alu_op == OpMfhi) || (i_id_ex_alu_op == OpMflo);
  assign stall    = i_reset && (state_q == StBusy) && md_use;

  always_comb begin
    alu_res = '0;
    case (i_id_ex_alu_op)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpNor:   alu_res = ~(op_a | op_b);
      OpSlt:   alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OpSltu:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      OpSllv:  alu_res = op_b << shamt;
      OpSrlv:  alu_res = op_b >> shamt;
      OpSrav:  alu_res = $unsigned($signed(op_b) >>> shamt);
      OpMfhi:  alu_res = hi_q;
      OpMflo:  alu_res = lo_q;
      OpLui:   alu_res = op_b << (DATA_WIDTH / 2);
      default: alu_res = '0;
    endcase
  end

  // acc holds the running high half (mul) or partial remainder (div); wrk holds the
  // multiplier shifting out / dividend shifting out while quotient bits shift in.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (wrk_q[0] ? opnd_q : {DATA_WIDTH{1'b0}})};
    div_shift = {acc_q, wrk_q[DATA_WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[DATA_WIDTH-1:0] - opnd_q;
    if (div_q) begin
      acc_nxt = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
      wrk_nxt = {wrk_q[DATA_WIDTH-2:0], div_ge};
    end else begin
      acc_nxt = mul_sum[DATA_WIDTH:1];
      wrk_nxt = {mul_sum[0], wrk_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (md_start) begin
          state_d = StBusy;
          cnt_d   = CntW'(DATA_WIDTH);
          div_d   = (i_id_ex_alu_op == OpDivu);
          acc_d   = '0;
          wrk_d   = op_a;
          opnd_d  = op_b;
        end
      end
      StBusy: begin
        acc_d = acc_nxt;
        wrk_d = wrk_nxt;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          hi_d    = acc_nxt;
          lo_d    = wrk_nxt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      acc_q   <= '0;
      wrk_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_ex_m_alu_result <= '0;
      o_ex_m_write_data <= '0;
      o_ex_m_rd         <= '0;
      o_ex_m_ctrl       <= '0;
    end else if (stall) begin
      o_ex_m_alu_result <= '0;
      o_ex_m_write_data <= '0;
      o_ex_m_rd         <= '0;
      o_ex_m_ctrl       <= '0;
    end else begin
      o_ex_m_alu_result <= alu_res;
      o_ex_m_write_data <= fwd_b;
      o_ex_m_rd         <= dest;
      // Multiply/divide results only reach the register file via MFHI/MFLO.
      o_ex_m_ctrl       <= md_start ? 4'b0000 : i_id_ex_ctrl;
    end
  end

  assign o_ex_stall    = stall;
  assign o_muldiv_busy = (state_q == StBusy);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed bench for ex_muldiv_stage; a driver queues expected EX/M contents and a
// monitor compares them one cycle later.
module tb_ex_muldiv_stage;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4, NOR = 4'd5;
  localparam logic [3:0] SLT = 4'd6, SLTU = 4'd7, SLLV = 4'd8, SRLV = 4'd9, SRAV = 4'd10;
  localparam logic [3:0] MULTU = 4'd11, DIVU = 4'd12, MFHI = 4'd13, MFLO = 4'd14, LUI = 4'd15;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_id_ex_data_1, i_id_ex_data_2, i_id_ex_extended_beq_offset;
  logic [4:0]  i_id_ex_rs, i_id_ex_rt, i_id_ex_rd;
  logic        i_id_ex_reg_dst, i_id_ex_alu_src;
  logic [3:0]  i_id_ex_alu_op, i_id_ex_ctrl;
  logic [31:0] i_ex_m_alu_result, i_m_wb_data_write;
  logic        i_ex_m_reg_write, i_m_wb_reg_write;
  logic [4:0]  i_ex_m_rd, i_m_wb_rd;
  logic [31:0] o_ex_m_alu_result, o_ex_m_write_data;
  logic [4:0]  o_ex_m_rd;
  logic [3:0]  o_ex_m_ctrl;
  logic        o_ex_stall, o_muldiv_busy;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_muldiv_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .i_clk                       (clk),
    .i_reset                     (i_reset),
    .i_id_ex_data_1              (i_id_ex_data_1),
    .i_id_ex_data_2              (i_id_ex_data_2),
    .i_id_ex_rs                  (i_id_ex_rs),
    .i_id_ex_rt                  (i_id_ex_rt),
    .i_id_ex_rd                  (i_id_ex_rd),
    .i_id_ex_extended_beq_offset (i_id_ex_extended_beq_offset),
    .i_id_ex_reg_dst             (i_id_ex_reg_dst),
    .i_id_ex_alu_src             (i_id_ex_alu_src),
    .i_id_ex_alu_op              (i_id_ex_alu_op),
    .i_id_ex_ctrl                (i_id_ex_ctrl),
    .i_ex_m_alu_result           (i_ex_m_alu_result),
    .i_ex_m_reg_write            (i_ex_m_reg_write),
    .i_ex_m_rd                   (i_ex_m_rd),
    .i_m_wb_data_write           (i_m_wb_data_write),
    .i_m_wb_reg_write            (i_m_wb_reg_write),
    .i_m_wb_rd                   (i_m_wb_rd),
    .o_ex_m_alu_result           (o_ex_m_alu_result),
    .o_ex_m_write_data           (o_ex_m_write_data),
    .o_ex_m_rd                   (o_ex_m_rd),
    .o_ex_m_ctrl                 (o_ex_m_ctrl),
    .o_ex_stall                  (o_ex_stall),
    .o_muldiv_busy               (o_muldiv_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (i_reset && q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_res) check("alu_result", o_ex_m_alu_result, e.res);
      check("write_data", o_ex_m_write_data, e.wd);
      check("rd", 32'(o_ex_m_rd), 32'(e.rd));
      check("ctrl", 32'(o_ex_m_ctrl), 32'(e.ctrl));
    end
  end

  // Called at a negedge; drives one ID/EX instruction and queues its EX/M expectation.
  task automatic issue(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic src, input logic dst,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] ctrl,
                       input logic [31:0] er, input logic [31:0] ewd, input logic [4:0] erd,
                       input logic [3:0] ectrl, input logic estall);
    exp_t e;
    i_id_ex_alu_op = op;
    i_id_ex_data_1 = d1;
    i_id_ex_data_2 = d2;
    i_id_ex_extended_beq_offset = imm;
    i_id_ex_alu_src = src;
    i_id_ex_reg_dst = dst;
    i_id_ex_rt = rt;
    i_id_ex_rd = rd;
    i_id_ex_ctrl = ctrl;
    #1;
    check("stall", 32'(o_ex_stall), 32'(estall));
    if (estall) begin
      e.res = '0; e.chk_res = 1'b1; e.wd = '0; e.rd = '0; e.ctrl = '0;
    end else begin
      e.res = er; e.chk_res = !(op == MULTU || op == DIVU);
      e.wd = ewd; e.rd = erd; e.ctrl = ectrl;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Register-register op, destination rd=3, ctrl=0001 (forced to 0 for MULTU/DIVU).
  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    issue(op, a, b, 32'h0, 1'b0, 1'b1, 5'd2, 5'd3, 4'b0001, exp, b, 5'd3,
          (op == MULTU || op == DIVU) ? 4'b0000 : 4'b0001, 1'b0);
  endtask

  task automatic stall_n(input logic [3:0] op, input int n);
    for (int i = 0; i < n; i++) begin
      check("busy", 32'(o_muldiv_busy), 32'd1);
      issue(op, 32'h5, 32'h6, 32'h0, 1'b0, 1'b1, 5'd2, 5'd3, 4'b0001,
            32'h0, 32'h0, 5'd0, 4'd0, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0;
    i_id_ex_data_1 = '0; i_id_ex_data_2 = '0; i_id_ex_extended_beq_offset = '0;
    i_id_ex_rs = 5'd1; i_id_ex_rt = 5'd2; i_id_ex_rd = 5'd3;
    i_id_ex_reg_dst = 1'b0; i_id_ex_alu_src = 1'b0; i_id_ex_alu_op = ADD; i_id_ex_ctrl = '0;
    i_ex_m_alu_result = '0; i_ex_m_reg_write = 1'b0; i_ex_m_rd = '0;
    i_m_wb_data_write = '0; i_m_wb_reg_write = 1'b0; i_m_wb_rd = '0;
    repeat (2) @(negedge clk);
    check("reset_result", o_ex_m_alu_result, 32'h0);
    check("reset_ctrl", 32'(o_ex_m_ctrl), 32'h0);
    check("reset_busy", 32'(o_muldiv_busy), 32'h0);
    check("reset_stall", 32'(o_ex_stall), 32'h0);
    i_reset = 1'b1;

    // ADD with immediate, destination rt
    issue(ADD, 32'h0, 32'h77, 32'h5, 1'b1, 1'b0, 5'd9, 5'd3, 4'b0001,
          32'h5, 32'h77, 5'd9, 4'b0001, 1'b0);
    alu(SUB,  32'd10, 32'd3, 32'd7);
    alu(SUB,  32'd0, 32'd1, 32'hFFFF_FFFF);
    alu(ADD,  32'hFFFF_FFFF, 32'd2, 32'd1);
    alu(AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    alu(OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
    alu(XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    alu(NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000);
    alu(SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
    alu(SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu(SLLV, 32'd36, 32'd1, 32'h10);
    alu(SRLV, 32'd4, 32'h8000_0000, 32'h0800_0000);
    alu(SRAV, 32'd4, 32'h8000_0000, 32'hF800_0000);
    issue(LUI, 32'h0, 32'hAB, 32'h1234, 1'b1, 1'b1, 5'd2, 5'd7, 4'b0011,
          32'h1234_0000, 32'hAB, 5'd7, 4'b0011, 1'b0);

    // Forwarding on A: EX/M wins, then M/WB, then register 0 never forwards
    i_id_ex_rs = 5'd8;
    i_ex_m_rd = 5'd8; i_ex_m_alu_result = 32'd100; i_ex_m_reg_write = 1'b1;
    i_m_wb_rd = 5'd8; i_m_wb_data_write = 32'd200; i_m_wb_reg_write = 1'b1;
    alu(ADD, 32'd1, 32'd0, 32'd100);
    i_ex_m_reg_write = 1'b0;
    alu(ADD, 32'd1, 32'd0, 32'd200);
    i_id_ex_rs = 5'd0; i_ex_m_rd = 5'd0; i_m_wb_rd = 5'd0; i_ex_m_reg_write = 1'b1;
    alu(ADD, 32'd1, 32'd0, 32'd1);
    // Forwarding on B, with and without the immediate
    i_id_ex_rs = 5'd1; i_ex_m_rd = 5'd8; i_m_wb_rd = 5'd8;
    issue(ADD, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 5'd8, 5'd3, 4'b0001,
          32'd101, 32'd100, 5'd3, 4'b0001, 1'b0);
    issue(ADD, 32'd1, 32'd0, 32'd5, 1'b1, 1'b1, 5'd8, 5'd3, 4'b0001,
          32'd6, 32'd100, 5'd3, 4'b0001, 1'b0);
    i_ex_m_reg_write = 1'b0; i_m_wb_reg_write = 1'b0;

    // MULTU then dependent MFLO stalls for the full iteration count
    alu(MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0);
    stall_n(MFLO, 32);
    alu(MFLO, 32'h0, 32'h0, 32'hFFFF_FFFE);
    check("busy_done", 32'(o_muldiv_busy), 32'd0);
    alu(MFHI, 32'h0, 32'h0, 32'h1);

    // DIVU with an independent ADD overlapping the busy period
    alu(DIVU, 32'd100, 32'd7, 32'h0);
    alu(ADD, 32'd2, 32'd3, 32'd5);
    stall_n(MFLO, 31);
    alu(MFLO, 32'h0, 32'h0, 32'd14);
    alu(MFHI, 32'h0, 32'h0, 32'd2);

    alu(DIVU, 32'd7, 32'd0, 32'h0);
    stall_n(MFHI, 32);
    alu(MFHI, 32'h0, 32'h0, 32'd7);
    alu(MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF);

    // Asynchronous reset during the tenth busy cycle
    alu(MULTU, 32'd3, 32'd5, 32'h0);
    stall_n(MFLO, 8);
    alu(ADD, 32'd10, 32'd20, 32'd30);
    i_id_ex_alu_op = MFLO;
    #1;
    check("stall_before_reset", 32'(o_ex_stall), 32'd1);
    i_reset = 1'b0;
    #1;
    check("async_result", o_ex_m_alu_result, 32'h0);
    check("async_write_data", o_ex_m_write_data, 32'h0);
    check("async_rd", 32'(o_ex_m_rd), 32'h0);
    check("async_ctrl", 32'(o_ex_m_ctrl), 32'h0);
    check("async_busy", 32'(o_muldiv_busy), 32'h0);
    check("async_stall", 32'(o_ex_stall), 32'h0);
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    alu(ADD, 32'd1, 32'd1, 32'd2);
    alu(MFHI, 32'h0, 32'h0, 32'h0);
    alu(MFLO, 32'h0, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
